// File: rtl/mem_pkg.sv
// Shared types and constants for the memory_interface slave endpoints.
package mem_pkg;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 16;

  // Latency counter width; covers the LATENCY range 1..15.
  localparam int CNT_W = 4;

  // Saturation ceiling for the optional access counters.
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, GAP} mem_slv_state_t;

  typedef logic [DATA_W-1:0] mem_word_t;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == STAT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_storage_array.sv
// Word array for mem_slave_sram: one synchronous write port and one
// registered read port. The array itself is never reset.
module mem_storage_array
  import mem_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  mem_word_t       wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output mem_word_t       rdata_o
);

  mem_word_t mem_q [DEPTH];
  mem_word_t rdata_q;

  // Write port: commit the word on the clock edge when enabled.
  // NOTE: storage arrays get no reset branch; resetting every word would block RAM inference and costs a huge reset tree.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: register the addressed word; it holds until the next read.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_slave_sram.sv
// mem_slave_sram: single-beat req/ack slave backed by an on-chip word array.
// Fixed response latency LATENCY (1..15) from the req-sampling edge to ack.
// Optional feature: define MEM_SLAVE_STATS_EN to add saturating read/write
// counters on rd_cnt_o / wr_cnt_o. Define ENABLE_ASSERTIONS for protocol SVA.
module mem_slave_sram
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_req_i,
  input  logic              mem_w_en_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  inout  wire  [DATA_W-1:0] mem_data_io,
  output logic              mem_ack_o
`ifdef MEM_SLAVE_STATS_EN
  ,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  mem_slv_state_t  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]   addr_q;
  logic            in_range_q;
  logic            w_en_q;
  mem_word_t       wdata_q;
  logic            ack_q;
  logic            drive_q;

  logic            req_in_range;
  logic            accept;
  logic            arr_we;
  logic            arr_re;
  mem_word_t       arr_rdata;
  mem_word_t       rd_word;

  // Out-of-range addresses are flagged once at acceptance; only the low
  // index bits are kept since the flag covers the rest.
  assign req_in_range = ({1'b0, mem_addr_i} < DEPTH_L);
  assign accept       = (state_q == IDLE) && mem_req_i;

  // Reads fetch at the accepting edge; writes commit on the edge leaving ACK.
  assign arr_re = accept && !mem_w_en_i && req_in_range;
  assign arr_we = (state_q == ACK) && w_en_q && in_range_q;

  mem_storage_array #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .re_i    (arr_re),
    .raddr_i (mem_addr_i[AW-1:0]),
    .rdata_o (arr_rdata)
  );

  // Out-of-range reads return zero rather than whatever the array last held.
  assign rd_word     = in_range_q ? arr_rdata : '0;
  assign mem_data_io = drive_q ? rd_word : 'z;
  assign mem_ack_o   = ack_q;

  // Transaction FSM with request latches, latency counter and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      in_range_q <= 1'b0;
      w_en_q     <= 1'b0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      drive_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_req_i) begin
            addr_q     <= mem_addr_i[AW-1:0];
            in_range_q <= req_in_range;
            w_en_q     <= mem_w_en_i;
            if (mem_w_en_i) begin
              wdata_q <= mem_data_io;
            end
            cnt_q <= CNT_INIT;
            if (LATENCY == 1) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
              drive_q <= !mem_w_en_i;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!mem_req_i) begin
            // Master withdrew the request: abandon without ack or write.
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
              drive_q <= !w_en_q;
            end
          end
        end
        ACK: begin
          state_q <= GAP;
          ack_q   <= 1'b0;
          drive_q <= 1'b0;
        end
        GAP: begin
          // One dead cycle so a still-high req is not re-accepted.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_SLAVE_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  // Count every acked access, including out-of-range ones; aborts never reach ACK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == ACK) begin
      if (w_en_q) begin
        wr_cnt_q <= sat_inc(wr_cnt_q);
      end else begin
        rd_cnt_q <= sat_inc(rd_cnt_q);
      end
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

`ifdef ENABLE_ASSERTIONS
  a_ack_pulse : assert property (@(posedge clk) disable iff (!reset_n)
    mem_ack_o |=> !mem_ack_o);
  a_ack_req : assert property (@(posedge clk) disable iff (!reset_n)
    mem_ack_o |-> mem_req_i);
  a_no_ack_on_rise : assert property (@(posedge clk) disable iff (!reset_n)
    $rose(mem_req_i) |-> !mem_ack_o);
  a_rd_data_known : assert property (@(posedge clk) disable iff (!reset_n)
    (mem_ack_o && !w_en_q) |-> !$isunknown(mem_data_io));
`endif

endmodule
